// File: rtl/mac_accumulator_pkg.sv
// Shared types and saturation bounds for the saturating dot-product accumulator.
package mac_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Largest value representable in a signed len-bit word.
  function automatic longint sat_hi(input int unsigned len);
    return (longint'(1) <<< (len - 1)) - longint'(1);
  endfunction

  // Smallest value representable in a signed len-bit word.
  function automatic longint sat_lo(input int unsigned len);
    return -(longint'(1) <<< (len - 1));
  endfunction

endpackage

// File: rtl/mac.sv
// Combinational multiply-accumulate: out = in1*in2 + preResult at full 2*LEN precision.
module mac #(
  parameter int unsigned LEN = 8
) (
  input  logic signed [LEN-1:0]   in1,
  input  logic signed [LEN-1:0]   in2,
  input  logic signed [LEN-1:0]   preResult,
  output logic signed [2*LEN-1:0] out
);

  logic signed [2*LEN-1:0] prod_c;
  logic signed [2*LEN-1:0] pre_ext_c;

  always_comb begin
    prod_c    = (2*LEN)'(in1) * (2*LEN)'(in2);
    pre_ext_c = (2*LEN)'(preResult);
    out       = prod_c + pre_ext_c;
  end

endmodule

// File: rtl/mac_accumulator.sv
// Saturating signed dot-product engine: start/vec_len launch, valid/ready operand
// stream in, one valid/ready result out with a sticky overflow flag.
module mac_accumulator
  import mac_accumulator_pkg::*;
#(
  parameter int unsigned LEN   = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [CNT_W-1:0]      vec_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [LEN-1:0] in1,
  input  logic signed [LEN-1:0] in2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [LEN-1:0] result,
  output logic                  overflow,
  output logic                  busy
);

  localparam logic signed [2*LEN-1:0] SAT_HI = (2*LEN)'(sat_hi(LEN));
  localparam logic signed [2*LEN-1:0] SAT_LO = (2*LEN)'(sat_lo(LEN));

  state_e                  state_q, state_d;
  logic signed [LEN-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sticky_q, sticky_d;
  logic signed [LEN-1:0]   result_q, result_d;
  logic                    overflow_q, overflow_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;

  logic signed [2*LEN-1:0] mac_out_c;
  logic signed [LEN-1:0]   sat_c;
  logic                    clamped_c;

  mac #(.LEN(LEN)) u_mac (
    .in1       (in1),
    .in2       (in2),
    .preResult (acc_q),
    .out       (mac_out_c)
  );

  // Clamp the full-precision sum back into the accumulator range.
  always_comb begin
    sat_c     = LEN'(mac_out_c);
    clamped_c = 1'b0;
    if (mac_out_c > SAT_HI) begin
      sat_c     = LEN'(SAT_HI);
      clamped_c = 1'b1;
    end else if (mac_out_c < SAT_LO) begin
      sat_c     = LEN'(SAT_LO);
      clamped_c = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sticky_d   = sticky_q;
    result_d   = result_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = vec_len;
          if (vec_len == '0) begin
            state_d    = DONE;
            result_d   = '0;
            overflow_d = 1'b0;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (in_valid && in_ready_q) begin
          acc_d    = sat_c;
          sticky_d = sticky_q | clamped_c;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d    = DONE;
            result_d   = sat_c;
            overflow_d = sticky_q | clamped_c;
          end
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake outputs are registered, so derive them from the next state.
    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sticky_q    <= sticky_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed self-checking bench for mac_accumulator (LEN=8, CNT_W=8).
module tb_mac_accumulator;

  logic              clk;
  logic              rstn;
  logic              start;
  logic [7:0]        vec_len;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in1;
  logic signed [7:0] in2;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] result;
  logic              overflow;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  mac_accumulator #(.LEN(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .vec_len   (vec_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len);
    start   = 1'b1;
    vec_len = 8'(len);
    tick();
    start   = 1'b0;
  endtask

  task automatic feed(input int a, input int b);
    int waited;
    waited   = 0;
    in1      = 8'(a);
    in2      = 8'(b);
    in_valid = 1'b1;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready) check("feed_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic collect();
    int waited;
    waited    = 0;
    out_ready = 1'b1;
    while (!out_valid && waited < 20) begin
      tick();
      waited++;
    end
    if (!out_valid) check("collect_timeout", 0, 1);
    tick();
    out_ready = 1'b0;
    check("collect_ov_low", int'(out_valid), 0);
    check("collect_idle", int'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pat;
    int          accepts;

    rstn      = 1'b0;
    start     = 1'b0;
    vec_len   = '0;
    in_valid  = 1'b0;
    in1       = '0;
    in2       = '0;
    out_ready = 1'b0;

    #3;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_result", int'(result), 0);
    check("rst_overflow", int'(overflow), 0);
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // in_valid in IDLE is ignored
    in1      = 8'sd5;
    in2      = 8'sd5;
    in_valid = 1'b1;
    repeat (3) tick();
    check("idle_in_ready", int'(in_ready), 0);
    check("idle_busy", int'(busy), 0);
    in_valid = 1'b0;

    // Basic: 2*3 - 4*5 + 7*1 = -7
    do_start(3);
    check("basic_busy", int'(busy), 1);
    check("basic_in_ready", int'(in_ready), 1);
    feed(2, 3);
    feed(-4, 5);
    check("basic_ov_early", int'(out_valid), 0);
    feed(7, 1);
    check("basic_ov_latency", int'(out_valid), 1);
    check("basic_result", int'(result), -7);
    check("basic_overflow", int'(overflow), 0);
    check("basic_in_ready_done", int'(in_ready), 0);
    collect();
    check("basic_result_idle", int'(result), -7);

    // Positive saturation then recovery: clamp 127, then 126
    do_start(2);
    feed(100, 100);
    feed(-1, 1);
    check("sat_ov", int'(out_valid), 1);
    check("sat_result", int'(result), 126);
    check("sat_overflow", int'(overflow), 1);
    collect();
    check("sat_overflow_idle", int'(overflow), 1);

    // Negative saturation
    do_start(1);
    feed(-128, 127);
    check("neg_result", int'(result), -128);
    check("neg_overflow", int'(overflow), 1);
    collect();

    // Zero length
    do_start(0);
    check("zero_ov", int'(out_valid), 1);
    check("zero_result", int'(result), 0);
    check("zero_overflow", int'(overflow), 0);
    check("zero_in_ready", int'(in_ready), 0);
    collect();

    // Input backpressure: four (1,1) pairs with a gappy in_valid
    do_start(4);
    pat     = 16'b0010_1101_1001_0110;
    accepts = 0;
    in1     = 8'sd1;
    in2     = 8'sd1;
    for (int i = 0; i < 32 && accepts < 4; i++) begin
      in_valid = pat[i % 16];
      if (in_valid && in_ready) accepts++;
      tick();
    end
    in_valid = 1'b0;
    check("bp_accepts", accepts, 4);
    check("bp_ov", int'(out_valid), 1);
    check("bp_result", int'(result), 4);

    // Output stall with a stray start during DONE
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        start   = 1'b1;
        vec_len = 8'd7;
      end
      tick();
      start = 1'b0;
      check("stall_ov", int'(out_valid), 1);
      check("stall_result", int'(result), 4);
    end
    collect();
    tick();
    check("stall_start_ignored", int'(busy), 0);
    check("stall_in_ready", int'(in_ready), 0);

    // Reset mid-operation
    do_start(4);
    feed(1, 1);
    feed(1, 1);
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_in_ready", int'(in_ready), 0);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_result", int'(result), 0);
    check("mid_rst_overflow", int'(overflow), 0);
    tick();
    rstn = 1'b1;
    tick();
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_ov", int'(out_valid), 0);
    do_start(1);
    feed(3, 3);
    check("post_rst_result", int'(result), 9);
    check("post_rst_overflow", int'(overflow), 0);
    collect();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
